// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command bundle between uart_rx and the command parser.
// The master side feeds received bytes and observes the command and status outputs.
// The slave side is the parser itself.
interface uart_cmd_parser_if;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       frm_err;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;

    modport master (
        output rx_done, rx_data,
        input  cmd_valid, cmd_addr, cmd_data, frm_err, err_code, busy, frame_cnt, err_cnt
    );

    modport slave (
        input  rx_done, rx_data,
        output cmd_valid, cmd_addr, cmd_data, frm_err, err_code, busy, frame_cnt, err_cnt
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frame parser for the UART command link.
// A frame is HEADER, addr, data and chk, where chk = (addr + data) mod 256.
// A good frame produces a one-cycle register-write command. A bad checksum or an
// inter-byte gap of TIMEOUT_CYC cycles drops the frame and flags it.
// Field bytes are purely positional: a HEADER value inside a frame is ordinary data.
module uart_cmd_parser #(
    parameter logic [7:0]  HEADER      = 8'hAA,
    parameter int unsigned TIMEOUT_CYC = 104160
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_cmd_parser_if.slave bus
);
    // Gap timer is at least 17 bits and wide enough to count up to TIMEOUT_CYC.
    localparam int TMR_W = ($clog2(TIMEOUT_CYC + 1) > 17) ? $clog2(TIMEOUT_CYC + 1) : 17;
    // The timeout fires on the edge where the timer would reach TIMEOUT_CYC,
    // so the compare uses the value one below it.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, CHK} state_t;

    state_t           state;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [TMR_W-1:0] gap_tmr;
    logic             timeout_hit;

    // 8-bit frame checksum; the carry is discarded.
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] s;
        s = a + d;
        return s;
    endfunction

    // Saturating increment for the drop counter.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign timeout_hit = (state != IDLE) && (gap_tmr == TMR_LAST);

    // Frame sequencing, gap timer and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gap_tmr       <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            bus.cmd_valid <= 1'b0;
            bus.cmd_addr  <= '0;
            bus.cmd_data  <= '0;
            bus.frm_err   <= 1'b0;
            bus.err_code  <= '0;
            bus.busy      <= 1'b0;
            bus.frame_cnt <= '0;
            bus.err_cnt   <= '0;
        end else begin
            bus.cmd_valid <= 1'b0;
            bus.frm_err   <= 1'b0;
            if (state == IDLE) begin
                gap_tmr <= '0;
                if (bus.rx_done && (bus.rx_data == HEADER)) begin
                    state    <= ADDR;
                    bus.busy <= 1'b1;
                end
            end else if (bus.rx_done) begin
                // An arriving byte always beats a coincident timeout.
                gap_tmr <= '0;
                case (state)
                    ADDR: begin
                        addr_q <= bus.rx_data;
                        state  <= DATA;
                    end
                    DATA: begin
                        data_q <= bus.rx_data;
                        state  <= CHK;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        if (bus.rx_data == frame_sum(addr_q, data_q)) begin
                            bus.cmd_valid <= 1'b1;
                            bus.cmd_addr  <= addr_q;
                            bus.cmd_data  <= data_q;
                            bus.frame_cnt <= bus.frame_cnt + 8'd1;
                        end else begin
                            bus.frm_err  <= 1'b1;
                            bus.err_code <= 2'b01;
                            bus.err_cnt  <= sat_inc(bus.err_cnt);
                        end
                    end
                endcase
            end else if (timeout_hit) begin
                state        <= IDLE;
                bus.busy     <= 1'b0;
                gap_tmr      <= '0;
                bus.frm_err  <= 1'b1;
                bus.err_code <= 2'b10;
                bus.err_cnt  <= sat_inc(bus.err_cnt);
            end else begin
                gap_tmr <= gap_tmr + TMR_W'(1);
            end
        end
    end
endmodule
